// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a run of consecutive BRAM words and streams
// them out in order through a 4-entry first-word-fall-through FIFO.
module bram_stream_reader #(
    parameter int BRAM_ADDR_WIDTH = 6,
    parameter int BRAM_DATA_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [BRAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [BRAM_ADDR_WIDTH:0]   length,
    output logic                       busy,
    output logic                       done,
    output logic [BRAM_ADDR_WIDTH-1:0] rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_dout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BRAM_DATA_WIDTH-1:0] out_data,
    output logic                       out_last
);

    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int DW = BRAM_DATA_WIDTH;
    localparam logic [AW-1:0] ADDR_ONE = 1;
    localparam logic [AW:0]   LEN_ONE  = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [AW:0]     len_q;
    logic [AW:0]     rem_q, rem_d;
    logic [AW:0]     dlv_q, dlv_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      flight_q;
    logic [DW-1:0]   fifo_q [4];
    logic [1:0]      wptr_q, rptr_q;
    logic [2:0]      occ_q, occ_d;
    logic [2:0]      pending;
    logic            issue;
    logic            accept;
    logic            push;
    logic            pop;
    logic            credit_ok;
    logic            last_word;

    // Reads land in the FIFO two edges after issue; the credit counts
    // both buffered words and reads still in the BRAM pipeline.
    assign push      = flight_q[1];
    assign out_valid = (occ_q != 3'd0);
    assign pop       = out_valid & out_ready;
    assign pending   = occ_q + {2'b00, flight_q[0]} + {2'b00, flight_q[1]};
    assign credit_ok = (pending < 3'd4);
    assign last_word = (dlv_q == (len_q - LEN_ONE));
    assign accept    = (state_q == S_IDLE) & start;
    assign out_data  = fifo_q[rptr_q];
    assign out_last  = out_valid & last_word;
    assign rd_addr   = addr_q;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if ((rem_q == '0) || (issue && (rem_q == LEN_ONE))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && last_word) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs; the first read is issued with the start.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        issue = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                issue = start && (length != '0);
            end
            S_READ: begin
                busy  = 1'b1;
                issue = (rem_q != '0) && credit_ok;
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
        endcase
    end

    // Next values for address, issue/delivery counters and occupancy.
    always_comb begin
        rem_d  = rem_q;
        addr_d = addr_q;
        dlv_d  = dlv_q;
        occ_d  = occ_q;
        if (issue) begin
            if (state_q == S_IDLE) begin
                rem_d  = length - LEN_ONE;
                addr_d = base_addr;
            end else begin
                rem_d  = rem_q - LEN_ONE;
                addr_d = addr_q + ADDR_ONE;
            end
        end
        if (accept) begin
            dlv_d = '0;
        end else if (pop) begin
            dlv_d = dlv_q + LEN_ONE;
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 3'd1;
            2'b01:   occ_d = occ_q - 3'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Command, counter and read-pipeline registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_q    <= '0;
            rem_q    <= '0;
            dlv_q    <= '0;
            addr_q   <= '0;
            occ_q    <= '0;
            flight_q <= '0;
        end else begin
            if (accept) begin
                len_q <= length;
            end
            rem_q    <= rem_d;
            dlv_q    <= dlv_d;
            addr_q   <= addr_d;
            occ_q    <= occ_d;
            flight_q <= {flight_q[0], issue};
        end
    end

    // FIFO storage and pointers; reset discards undelivered words.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= bram_dout;
                wptr_q         <= wptr_q + 2'd1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 2'd1;
            end
        end
    end

endmodule
